// File: rtl/membus_pkg.sv
// Shared definitions for the PDP-10 membus to Avalon bridge.
package membus_pkg;

  localparam int WORD_W = 36;
  localparam int MA_W   = 18;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RDRS   = 3'd2,
    ST_WRWAIT = 3'd3,
    ST_WR     = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/membus_avalon_bridge.sv
// PDP-10 membus slave port that turns processor memory cycles into single
// Avalon-MM read/write transactions on the local memory.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for an m_rq_cyc rise that hits this window
// RD        | a_read held until the slave drops waitrequest
// RDRS      | read data on m_mb_out with m_rd_rs for one cycle
// WRWAIT    | waiting for write-restart carrying the write data
// WR        | a_write held until the slave drops waitrequest
// DONE      | waiting for the processor to drop m_rq_cyc
module membus_avalon_bridge
  import membus_pkg::*;
#(
  parameter logic [MA_W-1:0] BASE      = 18'o000000,
  parameter int              SIZE_LOG2 = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_rq_cyc,
  input  logic              m_rd_rq,
  input  logic              m_wr_rq,
  input  logic [MA_W-1:0]   m_ma,
  input  logic              m_wr_rs,
  input  logic [WORD_W-1:0] m_mb_in,
  output logic              m_addr_ack,
  output logic              m_rd_rs,
  output logic [WORD_W-1:0] m_mb_out,
  output logic [MA_W-1:0]   a_address,
  output logic              a_read,
  output logic              a_write,
  output logic [WORD_W-1:0] a_writedata,
  input  logic [WORD_W-1:0] a_readdata,
  input  logic              a_waitrequest
);

  // Word-offset bits inside the window; everything above must match BASE.
  localparam logic [MA_W-1:0] OFS_MASK = MA_W'((64'd1 << SIZE_LOG2) - 64'd1);

  state_t              r_state;
  logic                r_prev_cyc;
  logic                r_wr_req;
  logic                r_abort;
  logic                r_addr_ack;
  logic                r_rd_rs;
  logic [WORD_W-1:0]   r_mb_out;
  logic [MA_W-1:0]     r_a_address;
  logic                r_a_read;
  logic                r_a_write;
  logic [WORD_W-1:0]   r_a_writedata;

  logic                w_hit;
  logic                w_start;

  // Decode a fresh cycle that targets this window with at least one request bit.
  always_comb begin
    w_hit   = (m_ma & ~OFS_MASK) == (BASE & ~OFS_MASK);
    w_start = m_rq_cyc && !r_prev_cyc && (m_rd_rq || m_wr_rq) && w_hit;
  end

  // Bus-cycle sequencer; all outputs come straight from registers. The
  // previous-cycle flag resets high so a cycle straddling reset is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_prev_cyc    <= 1'b1;
      r_wr_req      <= 1'b0;
      r_abort       <= 1'b0;
      r_addr_ack    <= 1'b0;
      r_rd_rs       <= 1'b0;
      r_mb_out      <= '0;
      r_a_address   <= '0;
      r_a_read      <= 1'b0;
      r_a_write     <= 1'b0;
      r_a_writedata <= '0;
    end else begin
      r_prev_cyc <= m_rq_cyc;
      r_addr_ack <= 1'b0;
      r_rd_rs    <= 1'b0;
      r_mb_out   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_a_address <= m_ma & OFS_MASK;
            r_wr_req    <= m_wr_rq;
            r_abort     <= 1'b0;
            r_addr_ack  <= 1'b1;
            if (m_rd_rq) begin
              r_a_read <= 1'b1;
              r_state  <= ST_RD;
            end else begin
              r_state  <= ST_WRWAIT;
            end
          end
        end
        ST_RD: begin
          // An abandoned read still completes on the slave side, silently.
          if (!m_rq_cyc) r_abort <= 1'b1;
          if (!a_waitrequest) begin
            r_a_read <= 1'b0;
            if (r_abort || !m_rq_cyc) begin
              r_state <= ST_IDLE;
            end else begin
              r_rd_rs  <= 1'b1;
              r_mb_out <= a_readdata;
              r_state  <= ST_RDRS;
            end
          end
        end
        ST_RDRS: begin
          if (!m_rq_cyc)     r_state <= ST_IDLE;
          else if (r_wr_req) r_state <= ST_WRWAIT;
          else               r_state <= ST_DONE;
        end
        ST_WRWAIT: begin
          if (!m_rq_cyc) begin
            r_state <= ST_IDLE;
          end else if (m_wr_rs) begin
            r_a_writedata <= m_mb_in;
            r_a_write     <= 1'b1;
            r_state       <= ST_WR;
          end
        end
        ST_WR: begin
          if (!m_rq_cyc) r_abort <= 1'b1;
          if (!a_waitrequest) begin
            r_a_write <= 1'b0;
            r_state   <= (r_abort || !m_rq_cyc) ? ST_IDLE : ST_DONE;
          end
        end
        ST_DONE: begin
          if (!m_rq_cyc) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_addr_ack  = r_addr_ack;
  assign m_rd_rs     = r_rd_rs;
  assign m_mb_out    = r_mb_out;
  assign a_address   = r_a_address;
  assign a_read      = r_a_read;
  assign a_write     = r_a_write;
  assign a_writedata = r_a_writedata;

endmodule

// File: tb/tb_membus_avalon_bridge.sv
// Directed bench for membus_avalon_bridge with a small Avalon memory model.
module tb_membus_avalon_bridge;
  import membus_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              m_rq_cyc, m_rd_rq, m_wr_rq, m_wr_rs;
  logic [MA_W-1:0]   m_ma;
  logic [WORD_W-1:0] m_mb_in;
  logic              m_addr_ack, m_rd_rs;
  logic [WORD_W-1:0] m_mb_out;
  logic [MA_W-1:0]   a_address;
  logic              a_read, a_write;
  logic [WORD_W-1:0] a_writedata, a_readdata;
  logic              a_waitrequest;

  membus_avalon_bridge dut (
    .clk(clk), .reset(reset),
    .m_rq_cyc(m_rq_cyc), .m_rd_rq(m_rd_rq), .m_wr_rq(m_wr_rq), .m_ma(m_ma),
    .m_wr_rs(m_wr_rs), .m_mb_in(m_mb_in),
    .m_addr_ack(m_addr_ack), .m_rd_rs(m_rd_rs), .m_mb_out(m_mb_out),
    .a_address(a_address), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_readdata(a_readdata),
    .a_waitrequest(a_waitrequest)
  );

  always #5 clk = ~clk;

  // Memory slave: waitrequest drops one cycle (plus extra_wait) after a request.
  logic [WORD_W-1:0] mem [0:16383];
  logic              s_ack = 1'b0;
  int                s_wcnt = 0;
  int                extra_wait = 0;

  assign a_waitrequest = !s_ack;
  assign a_readdata    = mem[a_address[13:0]];

  always @(posedge clk) begin
    if (!reset) begin
      mem[14'o1234] <= 36'o123456701234;
      mem[14'o100]  <= 36'o5;
    end
    if ((a_read || a_write) && !s_ack) begin
      if (s_wcnt < extra_wait) s_wcnt <= s_wcnt + 1;
      else begin s_ack <= 1'b1; s_wcnt <= 0; end
    end else begin
      s_ack <= 1'b0;
    end
    if (a_write && s_ack) mem[a_address[13:0]] <= a_writedata;
  end

  // Protocol monitor counters, sampled mid-cycle.
  int n_ack = 0, n_rdtx = 0, n_wrtx = 0, n_req = 0, n_wrcyc = 0;
  int both_err = 0, gap_err = 0, leak_err = 0;
  logic p_rd = 1'b0, p_wr = 1'b0;
  always @(negedge clk) begin
    if (m_addr_ack) n_ack++;
    if (a_read && !a_waitrequest) n_rdtx++;
    if (a_write && !a_waitrequest) n_wrtx++;
    if (a_read || a_write) n_req++;
    if (a_write) n_wrcyc++;
    if (a_read && a_write) both_err++;
    if ((p_rd && a_write) || (p_wr && a_read)) gap_err++;
    if (!m_rd_rs && m_mb_out != '0) leak_err++;
    p_rd = a_read;
    p_wr = a_write;
  end

  int n_checks = 0, n_errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a read cycle at ma and check the returned word; bounded wait.
  task automatic do_read(input logic [MA_W-1:0] ma, input logic [WORD_W-1:0] exp,
                         input string tag);
    bit found = 0;
    m_rq_cyc = 1'b1; m_rd_rq = 1'b1; m_wr_rq = 1'b0; m_ma = ma;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_rd_rs) found = 1;
    end
    chk({tag, "_rdrs_seen"}, 64'(found), 64'd1);
    chk({tag, "_data"}, 64'(m_mb_out), 64'(exp));
    m_rq_cyc = 1'b0; m_rd_rq = 1'b0;
    tick(); tick();
  endtask

  initial begin
    int a0, r0, w0, q0;
    bit found;
    reset = 1'b0;
    m_rq_cyc = 0; m_rd_rq = 0; m_wr_rq = 0; m_wr_rs = 0;
    m_ma = '0; m_mb_in = '0;
    repeat (3) tick();
    chk("rst_addr_ack", 64'(m_addr_ack), 0);
    chk("rst_rd_rs", 64'(m_rd_rs), 0);
    chk("rst_mb_out", 64'(m_mb_out), 0);
    chk("rst_a_read", 64'(a_read), 0);
    chk("rst_a_write", 64'(a_write), 0);
    chk("rst_a_address", 64'(a_address), 0);
    reset = 1'b1;
    tick();

    // Read with exact timing.
    m_rq_cyc = 1; m_rd_rq = 1; m_ma = 18'o1234;
    tick();
    chk("rd_t1_ack", 64'(m_addr_ack), 1);
    chk("rd_t1_aread", 64'(a_read), 1);
    chk("rd_t1_addr", 64'(a_address), 64'o1234);
    chk("rd_t1_rdrs", 64'(m_rd_rs), 0);
    tick();
    chk("rd_t2_ack", 64'(m_addr_ack), 0);
    chk("rd_t2_aread", 64'(a_read), 1);
    chk("rd_t2_mbout", 64'(m_mb_out), 0);
    tick();
    chk("rd_t3_rdrs", 64'(m_rd_rs), 1);
    chk("rd_t3_mbout", 64'(m_mb_out), 64'o123456701234);
    chk("rd_t3_aread", 64'(a_read), 0);
    m_wr_rs = 1; m_mb_in = 36'o111111111111;
    tick();
    m_wr_rs = 0;
    chk("rd_t4_rdrs", 64'(m_rd_rs), 0);
    chk("rd_t4_mbout", 64'(m_mb_out), 0);
    chk("rd_t4_done", 64'(dut.r_state), 64'(ST_DONE));
    tick();
    chk("rd_wrrs_ignored", 64'(a_write), 0);
    m_rq_cyc = 0; m_rd_rq = 0;
    tick();
    chk("rd_idle", 64'(dut.r_state), 64'(ST_IDLE));
    tick();

    // Write with exact timing.
    m_rq_cyc = 1; m_wr_rq = 1; m_ma = 18'o17;
    tick();
    chk("wr_ack", 64'(m_addr_ack), 1);
    chk("wr_no_aread", 64'(a_read), 0);
    chk("wr_wait", 64'(dut.r_state), 64'(ST_WRWAIT));
    tick(); tick();
    m_wr_rs = 1; m_mb_in = 36'o777000777000;
    tick();
    m_wr_rs = 0; m_mb_in = '0;
    chk("wr_u1_awrite", 64'(a_write), 1);
    chk("wr_u1_addr", 64'(a_address), 64'o17);
    chk("wr_u1_data", 64'(a_writedata), 64'o777000777000);
    tick();
    chk("wr_u2_awrite", 64'(a_write), 1);
    tick();
    chk("wr_u3_awrite", 64'(a_write), 0);
    chk("wr_u3_done", 64'(dut.r_state), 64'(ST_DONE));
    chk("wr_mem", 64'(mem[14'o17]), 64'o777000777000);
    m_rq_cyc = 0; m_wr_rq = 0;
    tick(); tick();
    do_read(18'o17, 36'o777000777000, "wr_readback");

    // Read-modify-write.
    r0 = n_rdtx; w0 = n_wrtx;
    m_rq_cyc = 1; m_rd_rq = 1; m_wr_rq = 1; m_ma = 18'o100;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_rd_rs) found = 1;
    end
    chk("rmw_rdrs_seen", 64'(found), 1);
    chk("rmw_rd_data", 64'(m_mb_out), 5);
    tick();
    m_wr_rs = 1; m_mb_in = 36'o6;
    tick();
    m_wr_rs = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (dut.r_state == ST_DONE) found = 1;
    end
    chk("rmw_done_seen", 64'(found), 1);
    chk("rmw_mem", 64'(mem[14'o100]), 6);
    chk("rmw_one_read", 64'(n_rdtx - r0), 1);
    chk("rmw_one_write", 64'(n_wrtx - w0), 1);
    m_rq_cyc = 0; m_rd_rq = 0; m_wr_rq = 0;
    tick(); tick();

    // Outside the window: no response at all.
    a0 = n_ack; q0 = n_req;
    m_rq_cyc = 1; m_rd_rq = 1; m_ma = 18'o040000;
    repeat (5) tick();
    chk("win_no_ack", 64'(n_ack - a0), 0);
    chk("win_no_req", 64'(n_req - q0), 0);
    m_rq_cyc = 0; m_rd_rq = 0;
    tick();

    // Abort in WRWAIT.
    w0 = n_wrcyc;
    m_rq_cyc = 1; m_wr_rq = 1; m_ma = 18'o20;
    tick(); tick();
    chk("abt_wrwait", 64'(dut.r_state), 64'(ST_WRWAIT));
    m_rq_cyc = 0; m_wr_rq = 0;
    tick();
    chk("abt_idle", 64'(dut.r_state), 64'(ST_IDLE));
    tick();
    chk("abt_no_write", 64'(n_wrcyc - w0), 0);
    do_read(18'o1234, 36'o123456701234, "abt_next");

    // Two extra slave wait cycles push m_rd_rs from t+3 to t+5.
    extra_wait = 2;
    m_rq_cyc = 1; m_rd_rq = 1; m_ma = 18'o1234;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("ws_rdrs_t%0d", i), 64'(m_rd_rs), (i == 5) ? 64'd1 : 64'd0);
    end
    chk("ws_data", 64'(m_mb_out), 64'o123456701234);
    extra_wait = 0;
    m_rq_cyc = 0; m_rd_rq = 0;
    tick(); tick();

    // Reset during RD, cycle held through release.
    m_rq_cyc = 1; m_rd_rq = 1; m_ma = 18'o1234;
    tick();
    chk("rr_aread", 64'(a_read), 1);
    reset = 0;
    tick();
    chk("rr_aread_drop", 64'(a_read), 0);
    chk("rr_ack_zero", 64'(m_addr_ack), 0);
    chk("rr_state", 64'(dut.r_state), 64'(ST_IDLE));
    reset = 1;
    a0 = n_ack;
    repeat (4) tick();
    chk("rr_no_ack_held", 64'(n_ack - a0), 0);
    m_rq_cyc = 0;
    tick();
    m_rq_cyc = 1;
    tick();
    chk("rr_ack_restart", 64'(m_addr_ack), 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_rd_rs) found = 1;
    end
    chk("rr_rdrs_seen", 64'(found), 1);
    chk("rr_data", 64'(m_mb_out), 64'o123456701234);
    m_rq_cyc = 0; m_rd_rq = 0;
    tick(); tick();

    chk("mon_both_high", 64'(both_err), 0);
    chk("mon_gap", 64'(gap_err), 0);
    chk("mon_mb_leak", 64'(leak_err), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/membus_avalon_bridge.md
# membus_avalon_bridge

Converts PDP-10 memory-bus cycles from the processor into 36-bit read/write transactions for the on-chip memory slave, which sits directly downstream. Each bridge instance claims one address window, answers address acknowledge, returns read data with a read-restart pulse, and accepts write data on write-restart. It supports read, write and read-modify-write cycles. All membus signals are synchronous to `clk`.

## Interface
- `BASE`, default 18'o000000: window base; only bits [17:SIZE_LOG2] are compared.
- `SIZE_LOG2`, default 14: window size in words (2^SIZE_LOG2).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low reset.
- `m_rq_cyc` in 1: processor requests a memory cycle; held for the whole cycle.
- `m_rd_rq` in 1: read requested; sampled with `m_rq_cyc` rise.
- `m_wr_rq` in 1: write requested; sampled with `m_rq_cyc` rise.
- `m_ma` in 18: word address; valid while `m_rq_cyc`.
- `m_wr_rs` in 1: write-restart, a 1-cycle pulse; `m_mb_in` valid in the same cycle.
- `m_mb_in` in 36: write data.
- `m_addr_ack` out 1: 1-cycle address acknowledge.
- `m_rd_rs` out 1: 1-cycle read-restart.
- `m_mb_out` out 36: read data; nonzero only while `m_rd_rs`=1, so the bus can be wired-OR.
- `a_address` out 18: `{0, m_ma[SIZE_LOG2-1:0]}` latched.
- `a_read` out 1, `a_write` out 1, `a_writedata` out 36: master request.
- `a_readdata` in 36, `a_waitrequest` in 1: slave response.

## Operation
- States: IDLE, RD, RDRS, WRWAIT, WR, DONE.
- Start condition: `m_rq_cyc` is high, its previous-cycle value is low, `m_rd_rq|m_wr_rq` is high, and `m_ma[17:SIZE_LOG2]==BASE[17:SIZE_LOG2]`.
- No match or no request bit: stay IDLE with no response. Another instance owns that address.
- IDLE → start:
  - latch address, `m_rd_rq` and `m_wr_rq`;
  - pulse `m_addr_ack`;
  - if `m_rd_rq`, go to RD and assert `a_read`; otherwise go to WRWAIT.
- RD: hold `a_read` until `a_waitrequest`=0. In that cycle, capture `a_readdata`, drop `a_read`, then go to RDRS.
- RDRS: `m_rd_rs`=1 and `m_mb_out`=captured data for exactly one cycle. Next state is WRWAIT if the latched `m_wr_rq` is set (RMW), otherwise DONE.
- WRWAIT: on `m_wr_rs`, latch `m_mb_in` into `a_writedata`, assert `a_write`, go to WR.
- WR: hold `a_write` until `a_waitrequest`=0, drop it, go to DONE.
- DONE: wait for `m_rq_cyc`=0, then go to IDLE.
- `m_rq_cyc` falls early:
  - in WRWAIT or RDRS: go to IDLE. No write occurs.
  - in RD or WR: finish the slave transaction (no `m_rd_rs` is emitted), then go to IDLE.
- `a_read` and `a_write` are never high together. Between transactions both are low for at least one cycle, because the slave's waitrequest lags by one cycle.
- Reset:
  - all outputs go to 0 and state goes to IDLE. Any pending slave request is dropped immediately.
  - the previous-`m_rq_cyc` register resets to 1, so a cycle already in progress through reset is ignored until `m_rq_cyc` falls.

## Timing
- All outputs are registered.
- Read, with `m_rq_cyc` rising in cycle t:
  - `m_addr_ack` and `a_read` are high in t+1;
  - the slave drops waitrequest in t+2, and data is captured;
  - `m_rd_rs` and `m_mb_out` are valid in t+3.
- Write, with `m_wr_rs` in cycle u: `a_write` is high in u+1 and u+2; the state is DONE in u+3.
- Extra slave wait cycles delay `m_rd_rs` and DONE by the same number of cycles.
- `m_wr_rs` outside WRWAIT is ignored.

## Structure
- Shared package `membus_pkg`: state encoding, `WORD_W`=36, `MA_W`=18.
- No sub-module. A single FSM with latch registers.

## Test plan
- Read: preload word 0o1234 = 36'o123456701234; cycle with rd_rq, ma=0o1234 → addr_ack at t+1, rd_rs with mb_out=36'o123456701234 at t+3, mb_out=0 otherwise.
- Write: wr_rq, ma=0o17; wr_rs with mb_in=36'o777000777000 → one a_write with address 0o17; a following read returns 36'o777000777000.
- RMW on 0o100 holding 36'o5: rd_rs returns 5; wr_rs with 6 → memory holds 6; exactly one a_read then one a_write, separated by ≥1 idle cycle.
- Window: BASE=0, ma=0o040000 → no addr_ack, no a_read/a_write.
- Abort: drop m_rq_cyc in WRWAIT → no a_write, state IDLE; next cycle starts normally.
- Reset: assert reset during RD → a_read=0 next cycle, all outputs 0; m_rq_cyc held high through release → no addr_ack until it falls and rises again.
